// File: rtl/mlp_pkg.sv
// mlp_pkg: shared defaults, requester indices and FSM state type for the
// activation-LUT sharing logic.
package mlp_pkg;

    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned TAG_W_DEF  = 8;

    // Requester indices into the two-entry request/response vectors
    localparam logic REQ_LAYER1 = 1'b0;
    localparam logic REQ_LAYER2 = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

endpackage

// File: rtl/lut_arbiter_if.sv
// lut_arbiter_if: request, LUT and response signals of the shared activation
// LUT. The slave modport is the arbiter; master is the requester/LUT side.
interface lut_arbiter_if
    import mlp_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned TAG_W  = TAG_W_DEF
) ();

    logic [1:0]             req_valid;
    logic [1:0]             req_ready;
    logic [1:0][DATA_W-1:0] req_data;
    logic [1:0][TAG_W-1:0]  req_tag;

    logic [DATA_W-1:0]      lut_in;
    logic                   lut_in_valid;
    logic [DATA_W-1:0]      lut_out;

    logic [1:0]             rsp_valid;
    logic [DATA_W-1:0]      rsp_data;
    logic [TAG_W-1:0]       rsp_tag;

    modport slave (
        input  req_valid, req_data, req_tag, lut_out,
        output req_ready, lut_in, lut_in_valid, rsp_valid, rsp_data, rsp_tag
    );

    modport master (
        output req_valid, req_data, req_tag, lut_out,
        input  req_ready, lut_in, lut_in_valid, rsp_valid, rsp_data, rsp_tag
    );

endinterface

// File: rtl/lut_tag_pipe.sv
// lut_tag_pipe: LUT_LAT-deep shift register of {valid, owner, tag} that
// tracks each LUT read so its result can be routed back to the issuer.
module lut_tag_pipe
    import mlp_pkg::*;
#(
    parameter int unsigned TAG_W   = TAG_W_DEF,
    parameter int unsigned LUT_LAT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             in_owner,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    output logic             out_owner,
    output logic [TAG_W-1:0] out_tag
);

    localparam int unsigned ENTRY_W = TAG_W + 2;

    logic [LUT_LAT-1:0][ENTRY_W-1:0] stage_q;

    // Advance one stage per cycle; reset drops every read still in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            stage_q <= '0;
        end else begin
            stage_q[0] <= {in_valid, in_owner, in_tag};
            for (int unsigned i = 1; i < LUT_LAT; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign {out_valid, out_owner, out_tag} = stage_q[LUT_LAT-1];

endmodule

// File: rtl/lut_arbiter.sv
// lut_arbiter: shares one activation LUT between the layer-1 reg-holder path
// (requester 0) and the layer-2 GSRAM path (requester 1). Round-robin with a
// bounded burst; tags ride alongside the LUT latency to route results back.
// Optional feature macro: LUT_ARB_STATS_EN adds saturating grant and
// contention counters.
module lut_arbiter
    import mlp_pkg::*;
#(
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned TAG_W     = TAG_W_DEF,
    parameter int unsigned LUT_LAT   = 1,
    parameter int unsigned MAX_BURST = 10
) (
    input  logic         clk,
    input  logic         reset,
    lut_arbiter_if.slave bus
`ifdef LUT_ARB_STATS_EN
    ,
    output logic [15:0]  grant_cnt0,
    output logic [15:0]  grant_cnt1,
    output logic [15:0]  contention_cnt
`endif
);

    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0] BURST_ONE = CNT_W'(1);

    arb_state_t       state_q, state_d;
    logic [CNT_W-1:0] burst_q, burst_d, burst_inc;
    logic             last_q, last_d;
    logic [1:0]       grant;
    logic [1:0]       v;

    logic [DATA_W-1:0] lut_in_q;
    logic              lut_in_valid_q;
    logic [TAG_W-1:0]  tag_q;
    logic              owner_q;

    logic              pipe_valid;
    logic              pipe_owner;
    logic [TAG_W-1:0]  pipe_tag;

    assign v         = bus.req_valid;
    assign burst_inc = (burst_q == BURST_MAX) ? burst_q : burst_q + BURST_ONE;

    // Arbitration state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            burst_q <= '0;
            last_q  <= REQ_LAYER2;
        end else begin
            state_q <= state_d;
            burst_q <= burst_d;
            last_q  <= last_d;
        end
    end

    // Grant decision and next state; the owner keeps the LUT until its burst
    // is used up and the other side is waiting.
    always_comb begin
        grant   = 2'b00;
        state_d = IDLE;
        burst_d = '0;
        last_d  = last_q;
        case (state_q)
            OWN0: begin
                if (v[REQ_LAYER1] && (burst_q < BURST_MAX || !v[REQ_LAYER2])) begin
                    grant[REQ_LAYER1] = 1'b1;
                end else if (v[REQ_LAYER2]) begin
                    grant[REQ_LAYER2] = 1'b1;
                end
            end
            OWN1: begin
                if (v[REQ_LAYER2] && (burst_q < BURST_MAX || !v[REQ_LAYER1])) begin
                    grant[REQ_LAYER2] = 1'b1;
                end else if (v[REQ_LAYER1]) begin
                    grant[REQ_LAYER1] = 1'b1;
                end
            end
            default: begin
                if (v[REQ_LAYER1] && v[REQ_LAYER2]) begin
                    grant[~last_q] = 1'b1;
                end else begin
                    grant = v;
                end
            end
        endcase

        if (grant[REQ_LAYER1]) begin
            state_d = OWN0;
            last_d  = REQ_LAYER1;
            burst_d = (state_q == OWN0) ? burst_inc : BURST_ONE;
        end else if (grant[REQ_LAYER2]) begin
            state_d = OWN1;
            last_d  = REQ_LAYER2;
            burst_d = (state_q == OWN1) ? burst_inc : BURST_ONE;
        end
    end

    assign bus.req_ready = grant;

    // Register the accepted request into the LUT strobe; value and tag hold
    // while no request is accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            lut_in_q       <= '0;
            lut_in_valid_q <= 1'b0;
            tag_q          <= '0;
            owner_q        <= REQ_LAYER1;
        end else begin
            lut_in_valid_q <= |grant;
            if (|grant) begin
                lut_in_q <= bus.req_data[grant[REQ_LAYER2]];
                tag_q    <= bus.req_tag[grant[REQ_LAYER2]];
                owner_q  <= grant[REQ_LAYER2];
            end
        end
    end

    assign bus.lut_in       = lut_in_q;
    assign bus.lut_in_valid = lut_in_valid_q;

    lut_tag_pipe #(
        .TAG_W   (TAG_W),
        .LUT_LAT (LUT_LAT)
    ) u_tag_pipe (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (lut_in_valid_q),
        .in_owner  (owner_q),
        .in_tag    (tag_q),
        .out_valid (pipe_valid),
        .out_owner (pipe_owner),
        .out_tag   (pipe_tag)
    );

    // Route the LUT result to the requester that issued the read.
    always_comb begin
        bus.rsp_valid = 2'b00;
        bus.rsp_tag   = '0;
        bus.rsp_data  = '0;
        if (pipe_valid) begin
            bus.rsp_valid[pipe_owner] = 1'b1;
            bus.rsp_tag               = pipe_tag;
            bus.rsp_data              = bus.lut_out;
        end
    end

`ifdef LUT_ARB_STATS_EN
    // Saturating per-requester grant counts and both-valid cycle count.
    always_ff @(posedge clk) begin
        if (reset) begin
            grant_cnt0     <= '0;
            grant_cnt1     <= '0;
            contention_cnt <= '0;
        end else begin
            if (grant[REQ_LAYER1] && grant_cnt0 != '1) grant_cnt0 <= grant_cnt0 + 16'd1;
            if (grant[REQ_LAYER2] && grant_cnt1 != '1) grant_cnt1 <= grant_cnt1 + 16'd1;
            if (v[REQ_LAYER1] && v[REQ_LAYER2] && contention_cnt != '1) begin
                contention_cnt <= contention_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_lut_arbiter.sv
// tb_lut_arbiter: random and directed stimulus against two arbiters
// (LUT_LAT=1 and LUT_LAT=3) sharing one request stream, checked against a
// transaction-level model of grant order and response timing.
module tb_lut_arbiter;
    import mlp_pkg::*;

    localparam int unsigned DW = 16;
    localparam int unsigned TW = 8;
    localparam int MB = 10;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    lut_arbiter_if #(.DATA_W(DW), .TAG_W(TW)) bus1 ();
    lut_arbiter_if #(.DATA_W(DW), .TAG_W(TW)) bus3 ();

    assign bus3.req_valid = bus1.req_valid;
    assign bus3.req_data  = bus1.req_data;
    assign bus3.req_tag   = bus1.req_tag;

`ifdef LUT_ARB_STATS_EN
    logic [15:0] gc0_1, gc1_1, cc_1, gc0_3, gc1_3, cc_3;
`endif

    lut_arbiter #(.DATA_W(DW), .TAG_W(TW), .LUT_LAT(1), .MAX_BURST(MB)) u_dut1 (
        .clk(clk), .reset(reset), .bus(bus1)
`ifdef LUT_ARB_STATS_EN
        , .grant_cnt0(gc0_1), .grant_cnt1(gc1_1), .contention_cnt(cc_1)
`endif
    );

    lut_arbiter #(.DATA_W(DW), .TAG_W(TW), .LUT_LAT(3), .MAX_BURST(MB)) u_dut3 (
        .clk(clk), .reset(reset), .bus(bus3)
`ifdef LUT_ARB_STATS_EN
        , .grant_cnt0(gc0_3), .grant_cnt1(gc1_3), .contention_cnt(cc_3)
`endif
    );

    // Behavioural LUT: fixed scramble function, LUT_LAT cycles after strobe
    function automatic logic [DW-1:0] lut_f(input logic [DW-1:0] x);
        return (x * 16'd40503) ^ 16'h5A5A;
    endfunction

    logic [DW-1:0] lut1_q;
    logic [DW-1:0] lut3_q [3];
    always @(posedge clk) begin
        lut1_q    <= lut_f(bus1.lut_in);
        lut3_q[0] <= lut_f(bus3.lut_in);
        lut3_q[1] <= lut3_q[0];
        lut3_q[2] <= lut3_q[1];
    end
    assign bus1.lut_out = lut1_q;
    assign bus3.lut_out = lut3_q[2];

    // Reference model
    typedef struct {
        int            due;
        logic          owner;
        logic [TW-1:0] tag;
        logic [DW-1:0] data;
    } rsp_t;

    rsp_t q1[$];
    rsp_t q3[$];
    int   m_owner;     // -1 when the previous cycle granted nobody
    int   m_run;       // consecutive grants to m_owner
    logic m_last;
    logic m_liv;
    logic [DW-1:0] m_lut_in;
    int   m_gc0, m_gc1, m_cc;
    int   cyc;

    int n_cmp = 0;
    int n_bad = 0;

    logic [89:0] exp_vec, obs_vec;
    logic [1:0]  obs_ready;
    int n_rsp0, n_rsp1, n_rsp3, n_liv;
    int first_rsp3, first_liv3;
    logic [TW-1:0] first_tag3;
    logic [DW-1:0] first_data3;

    function automatic int model_grant(input logic [1:0] v);
        if (v == 2'b00) return -1;
        if (v != 2'b11) return v[1] ? 1 : 0;
        if (m_owner < 0) return m_last ? 0 : 1;
        if (m_run < MB) return m_owner;
        return 1 - m_owner;
    endfunction

    function automatic logic [1:0] gvec(input int g);
        if (g < 0) return 2'b00;
        return (g == 0) ? 2'b01 : 2'b10;
    endfunction

    function automatic logic [1:0] ovec(input logic o);
        return o ? 2'b10 : 2'b01;
    endfunction

    task automatic model_reset();
        q1.delete();
        q3.delete();
        m_owner  = -1;
        m_run    = 0;
        m_last   = 1'b1;
        m_liv    = 1'b0;
        m_lut_in = '0;
        m_gc0    = 0;
        m_gc1    = 0;
        m_cc     = 0;
    endtask

    // One clock cycle: observe at negedge, build expectations, advance model
    task automatic tick();
        int   g;
        rsp_t e1, e3;
        bit   h1, h3;
        @(negedge clk);
        g  = model_grant(bus1.req_valid);
        h1 = (q1.size() > 0) && (q1[0].due == cyc);
        h3 = (q3.size() > 0) && (q3[0].due == cyc);
        if (h1) e1 = q1.pop_front();
        if (h3) e3 = q3.pop_front();
        exp_vec = {gvec(g), gvec(g), m_liv, m_liv, m_lut_in, m_lut_in,
                   h1 ? ovec(e1.owner) : 2'b00, h1 ? e1.tag : 8'h00, h1 ? e1.data : 16'h0000,
                   h3 ? ovec(e3.owner) : 2'b00, h3 ? e3.tag : 8'h00, h3 ? e3.data : 16'h0000};
        obs_vec = {bus1.req_ready, bus3.req_ready, bus1.lut_in_valid, bus3.lut_in_valid,
                   bus1.lut_in, bus3.lut_in,
                   bus1.rsp_valid, h1 ? bus1.rsp_tag : 8'h00, h1 ? bus1.rsp_data : 16'h0000,
                   bus3.rsp_valid, h3 ? bus3.rsp_tag : 8'h00, h3 ? bus3.rsp_data : 16'h0000};
        obs_ready = bus1.req_ready;
        if (bus1.rsp_valid[0]) n_rsp0++;
        if (bus1.rsp_valid[1]) n_rsp1++;
        if (bus3.rsp_valid != 2'b00) n_rsp3++;
        if (bus1.lut_in_valid) n_liv++;
        if (bus3.lut_in_valid && first_liv3 < 0) first_liv3 = cyc;
        if (bus3.rsp_valid != 2'b00 && first_rsp3 < 0) begin
            first_rsp3  = cyc;
            first_tag3  = bus3.rsp_tag;
            first_data3 = bus3.rsp_data;
        end
        @(posedge clk);
        if (reset) begin
            model_reset();
        end else begin
            if (bus1.req_valid == 2'b11 && m_cc < 65535) m_cc++;
            if (g >= 0) begin
                m_run    = (g == m_owner) ? m_run + 1 : 1;
                m_owner  = g;
                m_last   = g[0];
                m_liv    = 1'b1;
                m_lut_in = bus1.req_data[g];
                q1.push_back('{cyc + 2, g[0], bus1.req_tag[g], lut_f(bus1.req_data[g])});
                q3.push_back('{cyc + 4, g[0], bus1.req_tag[g], lut_f(bus1.req_data[g])});
                if (g == 0 && m_gc0 < 65535) m_gc0++;
                if (g == 1 && m_gc1 < 65535) m_gc1++;
            end else begin
                m_owner = -1;
                m_run   = 0;
                m_liv   = 1'b0;
            end
        end
        cyc++;
        #1;
    endtask

    task automatic clear_obs();
        n_rsp0 = 0; n_rsp1 = 0; n_rsp3 = 0; n_liv = 0;
        first_rsp3 = -1; first_liv3 = -1;
    endtask

    task automatic idle_req();
        bus1.req_valid = 2'b00;
    endtask

    task automatic do_reset();
        idle_req();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        idle_req();
        bus1.req_data = '0;
        bus1.req_tag  = '0;
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        n_cmp++;
        if ({bus1.req_ready, bus1.lut_in_valid, bus1.lut_in, bus1.rsp_valid, bus1.rsp_tag, bus1.rsp_data} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs_lat1 got ready=%b liv=%b lut_in=%h rsp=%b tag=%h data=%h want all zero",
                     bus1.req_ready, bus1.lut_in_valid, bus1.lut_in, bus1.rsp_valid, bus1.rsp_tag, bus1.rsp_data);
        end
        n_cmp++;
        if ({bus3.req_ready, bus3.lut_in_valid, bus3.lut_in, bus3.rsp_valid, bus3.rsp_tag, bus3.rsp_data} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs_lat3 got ready=%b liv=%b lut_in=%h rsp=%b tag=%h data=%h want all zero",
                     bus3.req_ready, bus3.lut_in_valid, bus3.lut_in, bus3.rsp_valid, bus3.rsp_tag, bus3.rsp_data);
        end
        repeat (2) begin
            tick();
            n_cmp++;
            if (obs_vec !== exp_vec) begin
                n_bad++;
                $display("FAIL reset_idle cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec);
            end
        end
    endtask

    task automatic test_single();
        int g0;
        clear_obs();
        g0 = 0;
        for (int i = 0; i < 10; i++) begin
            bus1.req_valid   = 2'b01;
            bus1.req_data[0] = DW'(i);
            bus1.req_tag[0]  = TW'(i);
            tick();
            if (obs_ready == 2'b01) g0++;
            n_cmp++;
            if (obs_vec !== exp_vec) begin
                n_bad++;
                $display("FAIL single cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec);
            end
        end
        idle_req();
        repeat (6) begin
            tick();
            n_cmp++;
            if (obs_vec !== exp_vec) begin
                n_bad++;
                $display("FAIL single_drain cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec);
            end
        end
        n_cmp++;
        if (g0 !== 10 || n_rsp0 !== 10 || n_rsp1 !== 0) begin
            n_bad++;
            $display("FAIL single_counts got grants=%0d rsp0=%0d rsp1=%0d want 10/10/0", g0, n_rsp0, n_rsp1);
        end
    endtask

    task automatic test_contention();
        do_reset();
        clear_obs();
        for (int i = 0; i < 40; i++) begin
            bus1.req_valid = 2'b11;
            bus1.req_data  = {DW'($urandom), DW'($urandom)};
            bus1.req_tag   = {TW'($urandom), TW'($urandom)};
            tick();
            n_cmp++;
            if (obs_ready !== (((i / 10) % 2 == 0) ? 2'b01 : 2'b10)) begin
                n_bad++;
                $display("FAIL contention_run i=%0d got ready=%b want=%b", i, obs_ready,
                         ((i / 10) % 2 == 0) ? 2'b01 : 2'b10);
            end
            n_cmp++;
            if (obs_vec !== exp_vec) begin
                n_bad++;
                $display("FAIL contention cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec);
            end
        end
        idle_req();
        tick();
        n_cmp++;
        if (n_liv !== 40) begin
            n_bad++;
            $display("FAIL contention_no_gap got lut_in_valid cycles=%0d want 40", n_liv);
        end
        repeat (6) begin
            tick();
            n_cmp++;
            if (obs_vec !== exp_vec) begin
                n_bad++;
                $display("FAIL contention_drain cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec);
            end
        end
        n_cmp++;
        if (n_rsp0 !== 20 || n_rsp1 !== 20) begin
            n_bad++;
            $display("FAIL contention_rsp got rsp0=%0d rsp1=%0d want 20/20", n_rsp0, n_rsp1);
        end
`ifdef LUT_ARB_STATS_EN
        n_cmp++;
        if (gc0_1 !== 16'd20 || gc1_1 !== 16'd20 || cc_1 !== 16'd40) begin
            n_bad++;
            $display("FAIL stats_contention got gc0=%0d gc1=%0d cc=%0d want 20/20/40", gc0_1, gc1_1, cc_1);
        end
`endif
    endtask

    task automatic test_owner_drop();
        idle_req();
        repeat (2) tick();
        for (int i = 0; i < 3; i++) begin
            bus1.req_valid   = 2'b10;
            bus1.req_data[1] = DW'($urandom);
            bus1.req_tag[1]  = TW'($urandom);
            tick();
            n_cmp++;
            if (obs_vec !== exp_vec) begin
                n_bad++;
                $display("FAIL drop_own1 cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec);
            end
        end
        bus1.req_valid   = 2'b01;
        bus1.req_data[0] = DW'($urandom);
        bus1.req_tag[0]  = TW'($urandom);
        tick();
        n_cmp++;
        if (obs_ready !== 2'b01) begin
            n_bad++;
            $display("FAIL drop_switch got ready=%b want=01", obs_ready);
        end
        // Fresh burst of 1 for req0: 9 more grants before req1 gets its turn
        for (int i = 0; i < 12; i++) begin
            bus1.req_valid = 2'b11;
            bus1.req_data  = {DW'($urandom), DW'($urandom)};
            bus1.req_tag   = {TW'($urandom), TW'($urandom)};
            tick();
            n_cmp++;
            if (obs_ready !== ((i < 9) ? 2'b01 : 2'b10)) begin
                n_bad++;
                $display("FAIL drop_burst i=%0d got ready=%b want=%b", i, obs_ready, (i < 9) ? 2'b01 : 2'b10);
            end
            n_cmp++;
            if (obs_vec !== exp_vec) begin
                n_bad++;
                $display("FAIL drop_both cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec);
            end
        end
        idle_req();
        repeat (6) tick();
    endtask

    task automatic test_latency();
        int            acc;
        logic [TW-1:0] t;
        logic [DW-1:0] d;
        idle_req();
        repeat (3) tick();
        clear_obs();
        t = TW'($urandom);
        d = DW'($urandom);
        acc = cyc;
        bus1.req_valid   = 2'b01;
        bus1.req_data[0] = d;
        bus1.req_tag[0]  = t;
        tick();
        idle_req();
        repeat (8) begin
            tick();
            n_cmp++;
            if (obs_vec !== exp_vec) begin
                n_bad++;
                $display("FAIL latency cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec);
            end
        end
        n_cmp++;
        if (first_liv3 !== acc + 1 || first_rsp3 !== acc + 4) begin
            n_bad++;
            $display("FAIL latency3_timing got strobe=%0d rsp=%0d want %0d/%0d", first_liv3, first_rsp3, acc + 1, acc + 4);
        end
        n_cmp++;
        if (first_tag3 !== t || first_data3 !== lut_f(d)) begin
            n_bad++;
            $display("FAIL latency3_payload got tag=%h data=%h want %h/%h", first_tag3, first_data3, t, lut_f(d));
        end
    endtask

    task automatic test_reset_mid();
        idle_req();
        repeat (2) tick();
        for (int i = 0; i < 2; i++) begin
            bus1.req_valid   = 2'b01;
            bus1.req_data[0] = DW'($urandom);
            bus1.req_tag[0]  = TW'($urandom);
            tick();
        end
        idle_req();
        reset = 1'b1;
        tick();
        n_cmp++;
        if (obs_vec !== exp_vec) begin
            n_bad++;
            $display("FAIL reset_mid_edge cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec);
        end
        reset = 1'b0;
        clear_obs();
        repeat (6) begin
            tick();
            n_cmp++;
            if (obs_vec !== exp_vec) begin
                n_bad++;
                $display("FAIL reset_mid_after cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec);
            end
        end
        n_cmp++;
        if (n_rsp0 + n_rsp1 + n_rsp3 !== 0) begin
            n_bad++;
            $display("FAIL reset_mid_dropped got rsp pulses=%0d want 0", n_rsp0 + n_rsp1 + n_rsp3);
        end
        bus1.req_valid = 2'b11;
        bus1.req_data  = {DW'($urandom), DW'($urandom)};
        bus1.req_tag   = {TW'($urandom), TW'($urandom)};
        tick();
        n_cmp++;
        if (obs_ready !== 2'b01) begin
            n_bad++;
            $display("FAIL reset_mid_tie got ready=%b want=01", obs_ready);
        end
        idle_req();
        repeat (6) tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            bus1.req_valid = {1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0)};
            bus1.req_data  = {DW'($urandom), DW'($urandom)};
            bus1.req_tag   = {TW'($urandom), TW'($urandom)};
            tick();
            n_cmp++;
            if (obs_vec !== exp_vec) begin
                n_bad++;
                $display("FAIL random cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec);
            end
        end
        idle_req();
        repeat (6) begin
            tick();
            n_cmp++;
            if (obs_vec !== exp_vec) begin
                n_bad++;
                $display("FAIL random_drain cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec);
            end
        end
`ifdef LUT_ARB_STATS_EN
        n_cmp++;
        if (gc0_1 !== 16'(m_gc0) || gc1_1 !== 16'(m_gc1) || cc_1 !== 16'(m_cc)) begin
            n_bad++;
            $display("FAIL stats_random got gc0=%0d gc1=%0d cc=%0d want %0d/%0d/%0d",
                     gc0_1, gc1_1, cc_1, m_gc0, m_gc1, m_cc);
        end
`endif
    endtask

    initial begin
        cyc = 0;
        model_reset();
        clear_obs();
        test_reset();
        test_single();
        test_contention();
        test_owner_drop();
        test_latency();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
